// File: rtl/riscv_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end.
package riscv_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [1:0] PRIV_MACHINE = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault_fetch;
    logic            fault_page;
  } fetch_resp_t;

endpackage

// File: rtl/riscv_fetch_stage_skid_buffer.sv
// One-entry holding register for a fetch response that decode could not take.
module riscv_fetch_stage_skid_buffer
  import riscv_fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  fetch_resp_t data_i,
  output logic        valid_o,
  output fetch_resp_t data_o
);

  logic        valid_q;
  fetch_resp_t data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/riscv_fetch_stage.sv
// Fetch front end: word-aligned I-cache reads, one outstanding, stale-response drop, skid to decode.
module riscv_fetch_stage
  import riscv_fetch_stage_pkg::*;
#(
  parameter int SUPPORT_MMU = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_accept_i,
  input  logic            icache_accept_i,
  input  logic            icache_valid_i,
  input  logic            icache_error_i,
  input  logic [31:0]     icache_inst_i,
  input  logic            icache_page_fault_i,
  input  logic            fetch_invalidate_i,
  input  logic            branch_request_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic [1:0]      branch_priv_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic [31:0]     fetch_instr_o,
  output logic            fetch_fault_fetch_o,
  output logic            fetch_fault_page_o,
  output logic            icache_rd_o,
  output logic            icache_flush_o,
  output logic            icache_invalidate_o,
  output logic [XLEN-1:0] icache_pc_o,
  output logic [1:0]      icache_priv_o,
  output logic            squash_decode_o
);

  localparam logic MMU_EN = (SUPPORT_MMU != 0);

  logic            active_q;
  logic            branch_q;
  logic            outstanding_q;
  logic [XLEN-1:0] pc_f_q;
  logic [XLEN-1:0] branch_pc_q;
  logic [XLEN-1:0] pc_d_q;
  logic [1:0]      priv_f_q;
  logic [1:0]      branch_priv_q;

  logic            fetch_addr_sel;
  logic [XLEN-1:0] fetch_addr;
  logic            busy;
  logic            issue;
  logic            drop;
  logic            resp_live;
  logic            skid_valid_q;
  logic            skid_load;
  logic            skid_clear;
  fetch_resp_t     resp_now;
  fetch_resp_t     skid_q;
  fetch_resp_t     resp_out;

  assign fetch_addr_sel = branch_q;
  assign fetch_addr     = fetch_addr_sel ? branch_pc_q : pc_f_q;
  assign icache_pc_o    = {fetch_addr[XLEN-1:2], 2'b00};
  assign icache_priv_o  = MMU_EN ? (branch_q ? branch_priv_q : priv_f_q) : PRIV_MACHINE;

  assign busy        = outstanding_q & ~icache_valid_i;
  assign icache_rd_o = active_q & fetch_accept_i & ~busy & ~skid_valid_q & ~branch_request_i;
  assign issue       = icache_rd_o & icache_accept_i;

  // A pending or arriving redirect makes any returning response stale.
  assign drop      = branch_request_i | branch_q;
  assign resp_live = icache_valid_i & ~drop;

  assign resp_now = '{pc:          pc_d_q,
                      instr:       icache_inst_i,
                      fault_fetch: icache_error_i,
                      fault_page:  icache_page_fault_i & MMU_EN};

  assign skid_load  = resp_live & ~skid_valid_q & ~fetch_accept_i;
  assign skid_clear = fetch_accept_i | branch_request_i;

  riscv_fetch_stage_skid_buffer u_fetch_skid_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (resp_now),
    .valid_o (skid_valid_q),
    .data_o  (skid_q)
  );

  assign resp_out      = skid_valid_q ? skid_q : resp_now;
  assign fetch_valid_o = skid_valid_q | resp_live;

  assign fetch_pc_o          = fetch_valid_o ? resp_out.pc : '0;
  assign fetch_instr_o       = fetch_valid_o ? resp_out.instr : '0;
  assign fetch_fault_fetch_o = fetch_valid_o & resp_out.fault_fetch;
  assign fetch_fault_page_o  = fetch_valid_o & resp_out.fault_page;

  assign icache_flush_o      = fetch_invalidate_i;
  assign icache_invalidate_o = 1'b0;
  assign squash_decode_o     = branch_request_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      active_q      <= 1'b0;
      branch_q      <= 1'b0;
      outstanding_q <= 1'b0;
      pc_f_q        <= '0;
      branch_pc_q   <= '0;
      pc_d_q        <= '0;
      priv_f_q      <= PRIV_MACHINE;
      branch_priv_q <= PRIV_MACHINE;
    end else begin
      if (issue) begin
        outstanding_q <= 1'b1;
        pc_d_q        <= icache_pc_o;
        pc_f_q        <= icache_pc_o + 32'd4;
        if (branch_q) begin
          branch_q <= 1'b0;
          priv_f_q <= branch_priv_q;
        end
      end else if (icache_valid_i) begin
        outstanding_q <= 1'b0;
      end
      // Issue is blocked during a request, so this never races the clear above.
      if (branch_request_i) begin
        active_q      <= 1'b1;
        branch_q      <= 1'b1;
        branch_pc_q   <= branch_pc_i;
        branch_priv_q <= branch_priv_i;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Scoreboarded bench for riscv_fetch_stage acting as I-cache and decode.
module tb_riscv_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ff;
    logic        fp;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_accept_i;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic        icache_error_i;
  logic [31:0] icache_inst_i;
  logic        icache_page_fault_i;
  logic        fetch_invalidate_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic [1:0]  branch_priv_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_instr_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;
  logic        icache_rd_o;
  logic        icache_flush_o;
  logic        icache_invalidate_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;
  logic        squash_decode_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  riscv_fetch_stage #(.SUPPORT_MMU(1)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .fetch_accept_i      (fetch_accept_i),
    .icache_accept_i     (icache_accept_i),
    .icache_valid_i      (icache_valid_i),
    .icache_error_i      (icache_error_i),
    .icache_inst_i       (icache_inst_i),
    .icache_page_fault_i (icache_page_fault_i),
    .fetch_invalidate_i  (fetch_invalidate_i),
    .branch_request_i    (branch_request_i),
    .branch_pc_i         (branch_pc_i),
    .branch_priv_i       (branch_priv_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_instr_o       (fetch_instr_o),
    .fetch_fault_fetch_o (fetch_fault_fetch_o),
    .fetch_fault_page_o  (fetch_fault_page_o),
    .icache_rd_o         (icache_rd_o),
    .icache_flush_o      (icache_flush_o),
    .icache_invalidate_o (icache_invalidate_o),
    .icache_pc_o         (icache_pc_o),
    .icache_priv_o       (icache_priv_o),
    .squash_decode_o     (squash_decode_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Decode side: every accepted delivery must match the oldest expected response.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i && fetch_valid_o && fetch_accept_i) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 64'(fetch_pc_o), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("out_pc", 64'(fetch_pc_o), 64'(e.pc));
        chk("out_instr", 64'(fetch_instr_o), 64'(e.instr));
        chk("out_ff", 64'(fetch_fault_fetch_o), 64'(e.ff));
        chk("out_fp", 64'(fetch_fault_page_o), 64'(e.fp));
      end
    end
  end

  task automatic issue_and_respond(input logic [31:0] pc, input logic [1:0] priv,
                                   input logic [31:0] instr, input logic err, input logic pf);
    icache_accept_i = 1'b1;
    @(negedge clk_i);
    chk("iss_rd", 64'(icache_rd_o), 64'h1);
    chk("iss_pc", 64'(icache_pc_o), 64'(pc));
    chk("iss_priv", 64'(icache_priv_o), 64'(priv));
    step();
    icache_accept_i     = 1'b0;
    icache_valid_i      = 1'b1;
    icache_inst_i       = instr;
    icache_error_i      = err;
    icache_page_fault_i = pf;
    sb.push_back('{pc: pc, instr: instr, ff: err, fp: pf});
    @(negedge clk_i);
    chk("rsp_valid", 64'(fetch_valid_o), 64'h1);
    step();
    icache_valid_i      = 1'b0;
    icache_inst_i       = '0;
    icache_error_i      = 1'b0;
    icache_page_fault_i = 1'b0;
  endtask

  initial begin
    rst_i               = 1'b0;
    fetch_accept_i      = 1'b1;
    icache_accept_i     = 1'b1;
    icache_valid_i      = 1'b0;
    icache_error_i      = 1'b0;
    icache_inst_i       = '0;
    icache_page_fault_i = 1'b0;
    fetch_invalidate_i  = 1'b0;
    branch_request_i    = 1'b0;
    branch_pc_i         = '0;
    branch_priv_i       = '0;

    @(negedge clk_i);
    chk("rst_rd", 64'(icache_rd_o), 64'h0);
    chk("rst_valid", 64'(fetch_valid_o), 64'h0);
    chk("rst_pc", 64'(icache_pc_o), 64'h0);
    chk("rst_priv", 64'(icache_priv_o), 64'h3);
    chk("rst_fpc", 64'(fetch_pc_o), 64'h0);
    step();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("boot_rd", 64'(icache_rd_o), 64'h0);
      chk("boot_valid", 64'(fetch_valid_o), 64'h0);
      step();
    end

    // Boot branch, then sequential fetch.
    icache_accept_i  = 1'b0;
    branch_request_i = 1'b1;
    branch_pc_i      = 32'hFACE_BEEF;
    branch_priv_i    = 2'b00;
    @(negedge clk_i);
    chk("boot_squash", 64'(squash_decode_o), 64'h1);
    chk("boot_req_rd", 64'(icache_rd_o), 64'h0);
    step();
    branch_request_i = 1'b0;
    issue_and_respond(32'hFACE_BEEC, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Redirect while a read is outstanding: its response is stale.
    icache_accept_i = 1'b1;
    @(negedge clk_i);
    chk("seq_pc", 64'(icache_pc_o), 64'hFACE_BEF0);
    step();
    icache_accept_i  = 1'b0;
    branch_request_i = 1'b1;
    branch_pc_i      = 32'hCAFE_BABE;
    branch_priv_i    = 2'b01;
    @(negedge clk_i);
    chk("br_squash", 64'(squash_decode_o), 64'h1);
    chk("br_rd", 64'(icache_rd_o), 64'h0);
    step();
    branch_request_i = 1'b0;
    icache_valid_i   = 1'b1;
    icache_inst_i    = 32'h1111_1111;
    @(negedge clk_i);
    chk("stale_valid", 64'(fetch_valid_o), 64'h0);
    chk("stale_squash", 64'(squash_decode_o), 64'h0);
    step();
    icache_valid_i = 1'b0;
    icache_inst_i  = '0;
    issue_and_respond(32'hCAFE_BABC, 2'b01, 32'h0000_0013, 1'b0, 1'b0);
    issue_and_respond(32'hCAFE_BAC0, 2'b01, 32'hAAAA_0001, 1'b1, 1'b0);
    issue_and_respond(32'hCAFE_BAC4, 2'b01, 32'hBBBB_0002, 1'b0, 1'b1);
    issue_and_respond(32'hCAFE_BAC8, 2'b01, 32'hCCCC_0003, 1'b0, 1'b0);

    // Decode stalls while a response returns: it waits in the skid buffer.
    icache_accept_i = 1'b1;
    @(negedge clk_i);
    chk("skid_iss_pc", 64'(icache_pc_o), 64'hCAFE_BACC);
    step();
    icache_accept_i = 1'b0;
    fetch_accept_i  = 1'b0;
    icache_valid_i  = 1'b1;
    icache_inst_i   = 32'h5555_AAAA;
    sb.push_back('{pc: 32'hCAFE_BACC, instr: 32'h5555_AAAA, ff: 1'b0, fp: 1'b0});
    @(negedge clk_i);
    chk("stall_valid", 64'(fetch_valid_o), 64'h1);
    chk("stall_rd", 64'(icache_rd_o), 64'h0);
    step();
    icache_valid_i = 1'b0;
    icache_inst_i  = '0;
    @(negedge clk_i);
    chk("skid_valid", 64'(fetch_valid_o), 64'h1);
    chk("skid_instr", 64'(fetch_instr_o), 64'h5555_AAAA);
    chk("skid_pc", 64'(fetch_pc_o), 64'hCAFE_BACC);
    step();
    fetch_accept_i = 1'b1;
    @(negedge clk_i);
    chk("skid_full_rd", 64'(icache_rd_o), 64'h0);
    step();
    @(negedge clk_i);
    chk("skid_free_rd", 64'(icache_rd_o), 64'h1);
    chk("skid_free_pc", 64'(icache_pc_o), 64'hCAFE_BAD0);
    chk("skid_free_valid", 64'(fetch_valid_o), 64'h0);

    // Flush is a same-cycle passthrough.
    step();
    fetch_invalidate_i = 1'b1;
    @(negedge clk_i);
    chk("flush_on", 64'(icache_flush_o), 64'h1);
    chk("inval_tie", 64'(icache_invalidate_o), 64'h0);
    step();
    fetch_invalidate_i = 1'b0;
    @(negedge clk_i);
    chk("flush_off", 64'(icache_flush_o), 64'h0);

    // Branch arriving together with a response: response dropped, target wins.
    icache_accept_i = 1'b1;
    step();
    icache_accept_i  = 1'b0;
    branch_request_i = 1'b1;
    branch_pc_i      = 32'hFFFF_FFFC;
    branch_priv_i    = 2'b11;
    icache_valid_i   = 1'b1;
    icache_inst_i    = 32'h2222_2222;
    @(negedge clk_i);
    chk("coll_valid", 64'(fetch_valid_o), 64'h0);
    chk("coll_squash", 64'(squash_decode_o), 64'h1);
    step();
    branch_request_i = 1'b0;
    icache_valid_i   = 1'b0;
    icache_inst_i    = '0;
    issue_and_respond(32'hFFFF_FFFC, 2'b11, 32'h3333_0004, 1'b0, 1'b0);
    issue_and_respond(32'h0000_0000, 2'b11, 32'h4444_0005, 1'b0, 1'b0);

    step();
    step();
    chk("sb_left", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
